// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_reader
//  Description : Read-side sequencer for the CPU register file. A Start pulse
//                in IDLE walks addresses FIRST_REG..LAST_REG over a single
//                combinational read port. Each (address, data) pair is
//                streamed out on a valid/ready channel for debug and trace.
//  Ports       : CLK       - clock, rising edge
//                clrn      - synchronous active-high reset
//                Start     - begin a dump (only honoured in IDLE)
//                Abort     - cancel a dump in progress
//                Busy      - high whenever not IDLE
//                ReadReg   - register file read address
//                ReadData  - register file read data for ReadReg
//                OutValid  - OutAddr/OutData/OutLast valid
//                OutReady  - consumer accept
//                OutAddr   - address of presented word
//                OutData   - captured register value
//                OutLast   - presented word is LAST_REG
//                Done      - one-cycle pulse after the last word is accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              CLK,
    input  logic              clrn,
    input  logic              Start,
    input  logic              Abort,
    output logic              Busy,
    output logic [ADDR_W-1:0] ReadReg,
    input  logic [DATA_W-1:0] ReadData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [DATA_W-1:0] OutData,
    output logic              OutLast,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(LAST_REG);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_READ    = 2'd1;
    localparam logic [1:0] c_PRESENT = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0] r_state;

    assign Busy = (r_state != c_IDLE);

    always_ff @(posedge CLK) begin
        if (clrn) begin
            r_state  <= c_IDLE;
            ReadReg  <= c_FIRST;
            OutValid <= 1'b0;
            OutAddr  <= '0;
            OutData  <= '0;
            OutLast  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            // Done is only ever raised on the PRESENT->DONE transition, so it
            // naturally lasts exactly one cycle (the DONE state itself).
            Done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        ReadReg <= c_FIRST;
                        r_state <= c_READ;
                    end
                end
                c_READ: begin
                    if (Abort) begin
                        r_state <= c_IDLE;
                    end else begin
                        // Snapshot the register now; later writes to this
                        // register are not reflected in the presented word.
                        OutData  <= ReadData;
                        OutAddr  <= ReadReg;
                        OutLast  <= (ReadReg == c_LAST);
                        OutValid <= 1'b1;
                        r_state  <= c_PRESENT;
                    end
                end
                c_PRESENT: begin
                    // Abort has priority over a simultaneous accept: the
                    // word is treated as not delivered.
                    if (Abort) begin
                        OutValid <= 1'b0;
                        r_state  <= c_IDLE;
                    end else if (OutReady) begin
                        OutValid <= 1'b0;
                        if (OutLast) begin
                            Done    <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            ReadReg <= ReadReg + 1'b1;
                            r_state <= c_READ;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
